operand_select_stage: RTL and testbench

OPERAND_SELECT_STAGE -- requirements
Module: operand_select_stage

---
 rtl/operand_select_stage_pkg.sv | 13 +
 rtl/operand_select_stage_fwd_select.sv | 34 +++
 rtl/operand_select_stage.sv | 160 ++++++++++++++++
 tb/tb_operand_select_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/operand_select_stage_pkg.sv
// Shared definitions for the operand select stage: forwarding-source encodings.
package operand_select_stage_pkg;

  // Forward source encoding driven on fwd_sel_a / fwd_sel_b
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  localparam int unsigned FWD_CNT_W = 16;

endpackage

// File: rtl/operand_select_stage_fwd_select.sv
// fwd_select: combinational forwarding mux for one source operand.
// EX/MEM has priority over MEM/WB; register index 0 is never forwarded.
module fwd_select
  import operand_select_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regwrite,
  input  logic [DATA_W-1:0] memwb_result,
  output fwd_sel_e          sel,
  output logic [DATA_W-1:0] value
);

  // Pick the youngest in-flight producer of rs, else the register file
  always_comb begin
    sel   = FWD_RF;
    value = rf_data;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs)) begin
      sel   = FWD_EXMEM;
      value = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs)) begin
      sel   = FWD_MEMWB;
      value = memwb_result;
    end
  end

endmodule

// File: rtl/operand_select_stage.sv
// operand_select_stage: forwards operands from later stages and registers the
// ALU operands, store data and forward selects with one cycle of latency.
// Optional macro FWD_STATS_EN adds saturating 16-bit forwarding counters.
module operand_select_stage
  import operand_select_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] imm_data,
  input  logic              alu_src,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              exmem_regwrite,
  input  logic              memwb_regwrite,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic [DATA_W-1:0] store_data,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b
`ifdef FWD_STATS_EN
  ,
  output logic [FWD_CNT_W-1:0] fwd_cnt_exmem,
  output logic [FWD_CNT_W-1:0] fwd_cnt_memwb
`endif
);

  fwd_sel_e          sel_a, sel_b;
  logic [DATA_W-1:0] val_a, val_b;

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .rs             (rs1),
    .rf_data        (read_data1),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_result   (exmem_result),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_result   (memwb_result),
    .sel            (sel_a),
    .value          (val_a)
  );

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .rs             (rs2),
    .rf_data        (read_data2),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_result   (exmem_result),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_result   (memwb_result),
    .sel            (sel_b),
    .value          (val_b)
  );

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] operand1_q, operand1_d;
  logic [DATA_W-1:0] operand2_q, operand2_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  fwd_sel_e          sel_a_q, sel_a_d;
  fwd_sel_e          sel_b_q, sel_b_d;
  logic              load;

  assign load = !flush && !stall;

  // Next output register state: flush drops valid only, stall holds, else load
  always_comb begin
    valid_d      = valid_q;
    operand1_d   = operand1_q;
    operand2_d   = operand2_q;
    store_data_d = store_data_q;
    sel_a_d      = sel_a_q;
    sel_b_d      = sel_b_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d      = in_valid;
      operand1_d   = val_a;
      operand2_d   = alu_src ? imm_data : val_b;
      store_data_d = val_b;
      sel_a_d      = sel_a;
      sel_b_d      = sel_b;
    end
  end

  // Output register with synchronous reset taking priority over stall/flush
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      operand1_q   <= '0;
      operand2_q   <= '0;
      store_data_q <= '0;
      sel_a_q      <= FWD_RF;
      sel_b_q      <= FWD_RF;
    end else begin
      valid_q      <= valid_d;
      operand1_q   <= operand1_d;
      operand2_q   <= operand2_d;
      store_data_q <= store_data_d;
      sel_a_q      <= sel_a_d;
      sel_b_q      <= sel_b_d;
    end
  end

  assign out_valid  = valid_q;
  assign operand1   = operand1_q;
  assign operand2   = operand2_q;
  assign store_data = store_data_q;
  assign fwd_sel_a  = sel_a_q;
  assign fwd_sel_b  = sel_b_q;

`ifdef FWD_STATS_EN
  logic [FWD_CNT_W-1:0] cnt_exmem_q, cnt_exmem_d;
  logic [FWD_CNT_W-1:0] cnt_memwb_q, cnt_memwb_d;
  logic [1:0]           inc_exmem, inc_memwb;
  logic [FWD_CNT_W:0]   sum_exmem, sum_memwb;

  // Saturating per-stage forward counts, advanced only on valid loads
  always_comb begin
    inc_exmem   = 2'(sel_a == FWD_EXMEM) + 2'(sel_b == FWD_EXMEM);
    inc_memwb   = 2'(sel_a == FWD_MEMWB) + 2'(sel_b == FWD_MEMWB);
    sum_exmem   = {1'b0, cnt_exmem_q} + {{(FWD_CNT_W-1){1'b0}}, inc_exmem};
    sum_memwb   = {1'b0, cnt_memwb_q} + {{(FWD_CNT_W-1){1'b0}}, inc_memwb};
    cnt_exmem_d = cnt_exmem_q;
    cnt_memwb_d = cnt_memwb_q;
    if (load && in_valid) begin
      cnt_exmem_d = sum_exmem[FWD_CNT_W] ? '1 : sum_exmem[FWD_CNT_W-1:0];
      cnt_memwb_d = sum_memwb[FWD_CNT_W] ? '1 : sum_memwb[FWD_CNT_W-1:0];
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_exmem_q <= '0;
      cnt_memwb_q <= '0;
    end else begin
      cnt_exmem_q <= cnt_exmem_d;
      cnt_memwb_q <= cnt_memwb_d;
    end
  end

  assign fwd_cnt_exmem = cnt_exmem_q;
  assign fwd_cnt_memwb = cnt_memwb_q;
`endif

endmodule

// File: tb/tb_operand_select_stage.sv
// Testbench for operand_select_stage: directed cases plus randomized cycles
// checked against a behavioural model of the forwarding rules.
module tb_operand_select_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, in_valid, stall, flush, alu_src;
  logic [DW-1:0] read_data1, read_data2, imm_data, exmem_result, memwb_result;
  logic [AW-1:0] rs1, rs2, exmem_rd, memwb_rd;
  logic          exmem_regwrite, memwb_regwrite;
  logic          out_valid;
  logic [DW-1:0] operand1, operand2, store_data;
  logic [1:0]    fwd_sel_a, fwd_sel_b;
`ifdef FWD_STATS_EN
  logic [15:0]   fwd_cnt_exmem, fwd_cnt_memwb;
`endif

  int checks = 0;
  int errors = 0;

  // expected registered state
  logic          m_v;
  logic [DW-1:0] m_op1, m_op2, m_sd;
  logic [1:0]    m_sa, m_sb;
  int            m_ce, m_cm;

  operand_select_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .read_data1(read_data1), .read_data2(read_data2), .imm_data(imm_data),
    .alu_src(alu_src), .rs1(rs1), .rs2(rs2), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .out_valid(out_valid), .operand1(operand1), .operand2(operand2),
    .store_data(store_data), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b)
`ifdef FWD_STATS_EN
    , .fwd_cnt_exmem(fwd_cnt_exmem), .fwd_cnt_memwb(fwd_cnt_memwb)
`endif
  );

  always #5 clk = ~clk;

  // Forwarding rule: youngest writer of a nonzero index wins
  function automatic void ref_fwd(input logic [AW-1:0] rs, input logic [DW-1:0] rf,
                                  output logic [1:0] sel, output logic [DW-1:0] val);
    if (rs != 0 && exmem_regwrite && exmem_rd == rs) begin
      sel = 2'd2; val = exmem_result;
    end else if (rs != 0 && memwb_regwrite && memwb_rd == rs) begin
      sel = 2'd1; val = memwb_result;
    end else begin
      sel = 2'd0; val = rf;
    end
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, m_v});
    chk({tag, ".op1"}, operand1, m_op1);
    chk({tag, ".op2"}, operand2, m_op2);
    chk({tag, ".sd"}, store_data, m_sd);
    chk({tag, ".sela"}, {30'b0, fwd_sel_a}, {30'b0, m_sa});
    chk({tag, ".selb"}, {30'b0, fwd_sel_b}, {30'b0, m_sb});
`ifdef FWD_STATS_EN
    chk({tag, ".cnte"}, {16'b0, fwd_cnt_exmem}, m_ce);
    chk({tag, ".cntm"}, {16'b0, fwd_cnt_memwb}, m_cm);
`endif
  endtask

  // Advance the model using the inputs as they stand at the coming edge, then clock
  task automatic edge_step();
    logic [1:0]    sa, sb;
    logic [DW-1:0] va, vb;
    int            ne, nm;
    ref_fwd(rs1, read_data1, sa, va);
    ref_fwd(rs2, read_data2, sb, vb);
    if (reset) begin
      m_v = 0; m_op1 = 0; m_op2 = 0; m_sd = 0; m_sa = 0; m_sb = 0; m_ce = 0; m_cm = 0;
    end else if (flush) begin
      m_v = 0;
    end else if (!stall) begin
      m_v = in_valid; m_op1 = va; m_op2 = alu_src ? imm_data : vb; m_sd = vb;
      m_sa = sa; m_sb = sb;
      if (in_valid) begin
        ne = (sa == 2) + (sb == 2);
        nm = (sa == 1) + (sb == 1);
        m_ce = (m_ce + ne > 65535) ? 65535 : m_ce + ne;
        m_cm = (m_cm + nm > 65535) ? 65535 : m_cm + nm;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    in_valid = 1'($urandom); alu_src = 1'($urandom);
    read_data1 = $urandom; read_data2 = $urandom; imm_data = $urandom;
    exmem_result = $urandom; memwb_result = $urandom;
    rs1 = AW'($urandom_range(0, 3)); rs2 = AW'($urandom_range(0, 3));
    exmem_rd = AW'($urandom_range(0, 3)); memwb_rd = AW'($urandom_range(0, 3));
    exmem_regwrite = 1'($urandom); memwb_regwrite = 1'($urandom);
  endtask

  task automatic clear_ctrl();
    reset = 0; stall = 0; flush = 0;
  endtask

  initial begin
    m_v = 'x; m_op1 = 'x; m_op2 = 'x; m_sd = 'x; m_sa = 'x; m_sb = 'x; m_ce = 0; m_cm = 0;
    rand_inputs();
    reset = 1; stall = 0; flush = 0;
    @(negedge clk);
    edge_step();
    check_all("reset");
    chk("reset.op1_zero", operand1, 32'h0);

    // EX/MEM beats MEM/WB on the same index
    clear_ctrl(); rand_inputs();
    in_valid = 1; rs1 = 3; exmem_rd = 3; memwb_rd = 3; exmem_regwrite = 1; memwb_regwrite = 1;
    exmem_result = 32'hAA; memwb_result = 32'hBB;
    edge_step();
    check_all("prio");
    chk("prio.op1_const", operand1, 32'hAA);
    chk("prio.sela_const", {30'b0, fwd_sel_a}, 32'd2);

    // index 0 never forwarded
    rand_inputs();
    rs2 = 0; exmem_rd = 0; exmem_regwrite = 1; read_data2 = 32'h55;
    edge_step();
    check_all("zero");
    chk("zero.sd_const", store_data, 32'h55);
    chk("zero.selb_const", {30'b0, fwd_sel_b}, 32'd0);

    // immediate operand, store data still forwarded
    rand_inputs();
    alu_src = 1; imm_data = 32'h10; rs2 = 2; exmem_rd = 1; memwb_rd = 2;
    memwb_regwrite = 1; memwb_result = 32'h77;
    edge_step();
    check_all("imm");
    chk("imm.op2_const", operand2, 32'h10);
    chk("imm.sd_const", store_data, 32'h77);

    // load, then hold for three stalled cycles with changing inputs
    rand_inputs(); in_valid = 1;
    edge_step();
    check_all("preload");
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); stall = 1;
      edge_step();
      check_all("stall");
    end
    rand_inputs(); stall = 1; flush = 1;
    edge_step();
    check_all("stallflush");
    chk("stallflush.valid_const", {31'b0, out_valid}, 32'd0);

    // reset wins over stall
    clear_ctrl(); rand_inputs(); in_valid = 1;
    edge_step();
    rand_inputs(); reset = 1; stall = 1;
    edge_step();
    check_all("rststall");
    chk("rststall.sd_zero", store_data, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      edge_step();
      check_all("rand");
    end

`ifdef FWD_STATS_EN
    // counters saturate at 0xFFFF
    clear_ctrl(); reset = 1;
    edge_step();
    clear_ctrl(); rand_inputs();
    in_valid = 1; rs1 = 1; rs2 = 1; exmem_rd = 1; exmem_regwrite = 1; memwb_regwrite = 0;
    for (int i = 0; i < 70000; i++) edge_step();
    check_all("sat");
    chk("sat.cnte_const", {16'b0, fwd_cnt_exmem}, 32'hFFFF);
    chk("sat.cntm_const", {16'b0, fwd_cnt_memwb}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
